id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage that registers decoded operands and control, then drives the ALU operand inputs `X`, `Y` and operation select `S`. It resolves data hazards by forwarding results from the EX/MEM and MEM/WB stages. It detects load-use hazards and inserts one bubble per hazard. It sits directly upstream of the ALU in the 5-stage RV32I core.

## Interface
- `XLEN`, 32, datapath width
- `RADDR`, 5, register-address width
- `clk  in  1`  rising-edge clock
- `rst_n  in  1`  asynchronous, active-low reset
- `id_valid  in  1`  decode slot holds a real instruction
- `id_rs1, id_rs2, id_rd  in  RADDR`  register addresses
- `id_rs1_data, id_rs2_data, id_imm, id_pc  in  XLEN`  operands
- `id_alu_sel  in  4`  ALU op (`alu_op_t`)
- `id_use_imm, id_use_pc, id_reg_write, id_mem_read, id_mem_write  in  1`  decoded controls
- `stall, flush  in  1`  pipeline control from hazard/branch logic
- `exmem_reg_write  in  1`, `exmem_rd  in  RADDR`, `exmem_result  in  XLEN`  EX/MEM forward source
- `memwb_reg_write  in  1`, `memwb_rd  in  RADDR`, `memwb_result  in  XLEN`  MEM/WB forward source
- `ex_valid  out  1`; `ex_x, ex_y, ex_store_data  out  XLEN`; `ex_s  out  4`; `ex_rd  out  RADDR`; `ex_reg_write, ex_mem_read, ex_mem_write  out  1`
- `load_use  out  1`  combinational; upstream must hold decode while it is high

## Operation
- Register update on each rising edge, in priority order:
  - `flush`: clear the valid bit and all write/mem controls.
  - `stall`: hold every register.
  - `load_use`: load a bubble (valid=0, controls=0). Data fields are don't-care.
  - Otherwise: capture all `id_*` fields.
- `load_use` = `ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((id_rs1==ex_rd) | (~id_use_imm & id_rs2==ex_rd))`.
- Forwarding is combinational from the registered `rs1`/`rs2` fields. Per operand:
  - EX/MEM match (`exmem_reg_write`, rd==rs, rd!=0) wins.
  - Otherwise MEM/WB match.
  - Otherwise the registered data.
  - x0 is never forwarded.
- Operand selection:
  - `ex_x` = `id_use_pc` ? registered pc : forwarded rs1.
  - `ex_y` = `id_use_imm` ? registered imm : forwarded rs2.
  - `ex_store_data` = forwarded rs2, always.
- `ex_s` = registered alu_sel. The ALU does not gate on valid.
- Outputs `ex_reg_write`, `ex_mem_read` and `ex_mem_write` are ANDed with `ex_valid`.

## Timing
- Reset (async assert, sync release): all registers 0; `ex_valid`=0, `ex_s`=0, `ex_x`=`ex_y`=`ex_store_data`=0, `load_use`=0.
- Latency: one cycle from an `id_*` field to its `ex_*` output. Forwarding adds no cycle.
- A load-use costs exactly one bubble. In the next cycle `ex_mem_read`=0, so `load_use` drops and the held instruction is captured.
- `stall` & `flush` in the same cycle: flush wins.
- `stall` & `load_use`: hold wins. No bubble is lost; hazard re-evaluates next cycle.
- Reset mid-stall: the stage empties; no partial instruction survives.
- Both forward sources match the same rs: EX/MEM (youngest) value is used.

## Structure
- Shared `riscv_pkg`: `alu_op_t` (4-bit op encodings used by ALU and decoder), `XLEN`, `RADDR`, and struct `id_ex_t` bundling the registered fields.
- One sub-module, `forward_unit`: pure combinational per-operand 2-level mux with match logic, instantiated twice (rs1, rs2).

## Test plan
- Reset then load: `id_rs1_data`=11, `id_rs2_data`=3, sel=1, valid=1 -> next cycle `ex_x`=11, `ex_y`=3, `ex_s`=1, `ex_valid`=1.
- Forward priority: rs1=5; exmem rd=5 result=0x10000; memwb rd=5 result=9 -> `ex_x`=0x10000. Drop exmem_reg_write -> `ex_x`=9. Set rs1=0 -> regfile value, no forwarding.
- Load-use: EX holds lw x7; ID holds add using x7 -> `load_use`=1 for one cycle; next `ex_valid`=0; following cycle the add is captured with `ex_x` forwarded from memwb.
- Immediate/PC select: `use_imm`=1, imm=0xFFFFFFF0, rs2 matches exmem -> `ex_y`=0xFFFFFFF0, `ex_store_data`=exmem_result. `use_pc`=1, pc=0x100 -> `ex_x`=0x100.
- Stall & flush together with valid stage contents -> next cycle `ex_valid`=0, `ex_reg_write`=0. Stall alone for 3 cycles -> outputs constant.
- Async reset asserted mid-cycle during stall -> all outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: datapath widths, ALU op encodings and the ID/EX pipeline register layout.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned RADDR     = 5;
    localparam int unsigned ALU_SEL_W = 4;

    typedef enum logic [ALU_SEL_W-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef struct packed {
        logic             valid;
        logic [RADDR-1:0] rs1;
        logic [RADDR-1:0] rs2;
        logic [RADDR-1:0] rd;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        alu_op_t          alu_sel;
        logic             use_imm;
        logic             use_pc;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
    } id_ex_t;

    // A writer only supplies a value for rs when it actually writes a non-x0 register
    function automatic logic fwd_match(input logic             we,
                                       input logic [RADDR-1:0] rd,
                                       input logic [RADDR-1:0] rs);
        return we && (rd == rs) && (rd != '0);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of decode inputs, forward sources, pipeline control and execute-side outputs of the ID/EX stage.
interface id_ex_stage_if;
    import riscv_pkg::*;

    logic                 id_valid;
    logic [RADDR-1:0]     id_rs1;
    logic [RADDR-1:0]     id_rs2;
    logic [RADDR-1:0]     id_rd;
    logic [XLEN-1:0]      id_rs1_data;
    logic [XLEN-1:0]      id_rs2_data;
    logic [XLEN-1:0]      id_imm;
    logic [XLEN-1:0]      id_pc;
    logic [ALU_SEL_W-1:0] id_alu_sel;
    logic                 id_use_imm;
    logic                 id_use_pc;
    logic                 id_reg_write;
    logic                 id_mem_read;
    logic                 id_mem_write;
    logic                 stall;
    logic                 flush;
    logic                 exmem_reg_write;
    logic [RADDR-1:0]     exmem_rd;
    logic [XLEN-1:0]      exmem_result;
    logic                 memwb_reg_write;
    logic [RADDR-1:0]     memwb_rd;
    logic [XLEN-1:0]      memwb_result;
    logic                 ex_valid;
    logic [XLEN-1:0]      ex_x;
    logic [XLEN-1:0]      ex_y;
    logic [XLEN-1:0]      ex_store_data;
    logic [ALU_SEL_W-1:0] ex_s;
    logic [RADDR-1:0]     ex_rd;
    logic                 ex_reg_write;
    logic                 ex_mem_read;
    logic                 ex_mem_write;
    logic                 load_use;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_alu_sel, id_use_imm, id_use_pc, id_reg_write, id_mem_read, id_mem_write,
               stall, flush, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  ex_valid, ex_x, ex_y, ex_store_data, ex_s, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, load_use
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_alu_sel, id_use_imm, id_use_pc, id_reg_write, id_mem_read, id_mem_write,
               stall, flush, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output ex_valid, ex_x, ex_y, ex_store_data, ex_s, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, load_use
    );

endinterface

// File: rtl/forward_unit.sv
// Per-operand bypass mux: EX/MEM result beats MEM/WB result beats the registered register-file value.
module forward_unit
    import riscv_pkg::*;
(
    input  logic [RADDR-1:0] rs,
    input  logic [XLEN-1:0]  reg_data,
    input  logic             exmem_reg_write,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [XLEN-1:0]  memwb_result,
    output logic [XLEN-1:0]  data_c
);

    always_comb begin
        data_c = reg_data;
        if (fwd_match(exmem_reg_write, exmem_rd, rs)) begin
            data_c = exmem_result;
        end else if (fwd_match(memwb_reg_write, memwb_rd, rs)) begin
            data_c = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion, feeding the ALU.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    id_ex_t          q;
    id_ex_t          d;
    logic [XLEN-1:0] rs1_fwd_c;
    logic [XLEN-1:0] rs2_fwd_c;

    // rs2 only matters for the hazard when it is really read (not replaced by the immediate)
    assign bus.load_use = q.valid && q.mem_read && (q.rd != '0) && bus.id_valid &&
                          ((bus.id_rs1 == q.rd) || (!bus.id_use_imm && (bus.id_rs2 == q.rd)));

    // Next-state priority: flush, stall, load-use bubble, capture
    always_comb begin
        d = q;
        if (bus.flush || (!bus.stall && bus.load_use)) begin
            d.valid     = 1'b0;
            d.reg_write = 1'b0;
            d.mem_read  = 1'b0;
            d.mem_write = 1'b0;
        end else if (!bus.stall) begin
            d.valid     = bus.id_valid;
            d.rs1       = bus.id_rs1;
            d.rs2       = bus.id_rs2;
            d.rd        = bus.id_rd;
            d.rs1_data  = bus.id_rs1_data;
            d.rs2_data  = bus.id_rs2_data;
            d.imm       = bus.id_imm;
            d.pc        = bus.id_pc;
            d.alu_sel   = alu_op_t'(bus.id_alu_sel);
            d.use_imm   = bus.id_use_imm;
            d.use_pc    = bus.id_use_pc;
            d.reg_write = bus.id_reg_write;
            d.mem_read  = bus.id_mem_read;
            d.mem_write = bus.id_mem_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

    forward_unit u_fwd_rs1 (
        .rs              (q.rs1),
        .reg_data        (q.rs1_data),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_result    (bus.memwb_result),
        .data_c          (rs1_fwd_c)
    );

    forward_unit u_fwd_rs2 (
        .rs              (q.rs2),
        .reg_data        (q.rs2_data),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_result    (bus.memwb_result),
        .data_c          (rs2_fwd_c)
    );

    assign bus.ex_valid      = q.valid;
    assign bus.ex_x          = q.use_pc  ? q.pc  : rs1_fwd_c;
    assign bus.ex_y          = q.use_imm ? q.imm : rs2_fwd_c;
    assign bus.ex_store_data = rs2_fwd_c;
    assign bus.ex_s          = ALU_SEL_W'(q.alu_sel);
    assign bus.ex_rd         = q.rd;
    assign bus.ex_reg_write  = q.reg_write && q.valid;
    assign bus.ex_mem_read   = q.mem_read  && q.valid;
    assign bus.ex_mem_write  = q.mem_write && q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus queues expected outputs per cycle, a negedge monitor compares them.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        int          cyc;
        logic        v;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] sd;
        logic [3:0]  s;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        lu;
        logic        chk;
    } exp_t;

    exp_t sb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this cycle's falling edge
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic ok;
            e  = sb.pop_front();
            ok = (bus.ex_valid == e.v) && (bus.ex_reg_write == e.rw) &&
                 (bus.ex_mem_read == e.mr) && (bus.ex_mem_write == e.mw) &&
                 (bus.load_use == e.lu);
            if (e.chk) begin
                ok = ok && (bus.ex_x == e.x) && (bus.ex_y == e.y) &&
                     (bus.ex_store_data == e.sd) && (bus.ex_s == e.s);
            end
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s: got v=%0b x=%h y=%h sd=%h s=%0d rw=%0b mr=%0b mw=%0b lu=%0b, expected v=%0b x=%h y=%h sd=%h s=%0d rw=%0b mr=%0b mw=%0b lu=%0b (data checked=%0b)",
                         e.name, bus.ex_valid, bus.ex_x, bus.ex_y, bus.ex_store_data, bus.ex_s,
                         bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.load_use,
                         e.v, e.x, e.y, e.sd, e.s, e.rw, e.mr, e.mw, e.lu, e.chk);
            end
        end
    end

    task automatic push(input string name, input logic v, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] sd, input logic [3:0] s, input logic rw, input logic mr,
                        input logic mw, input logic lu, input logic chk);
        exp_t e;
        e.name = name; e.cyc = cyc; e.v = v; e.x = x; e.y = y; e.sd = sd; e.s = s;
        e.rw = rw; e.mr = mr; e.mw = mw; e.lu = lu; e.chk = chk;
        sb.push_back(e);
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] sel,
                            input logic ui, input logic up, input logic rw, input logic mr,
                            input logic mw);
        bus.id_valid = v; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm; bus.id_pc = pc;
        bus.id_alu_sel = sel; bus.id_use_imm = ui; bus.id_use_pc = up;
        bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
    endtask

    task automatic fwd(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                       input logic mrw, input logic [4:0] mrd, input logic [31:0] mres);
        bus.exmem_reg_write = erw; bus.exmem_rd = erd; bus.exmem_result = eres;
        bus.memwb_reg_write = mrw; bus.memwb_rd = mrd; bus.memwb_result = mres;
    endtask

    // Each step: move just past the rising edge, then apply this cycle's inputs
    task automatic step(input logic st, input logic fl);
        @(posedge clk);
        #1;
        bus.stall = st;
        bus.flush = fl;
    endtask

    initial begin
        cyc = 0; checks = 0; failures = 0;
        rst_n = 1'b0;
        bus.stall = 1'b0; bus.flush = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        fwd(0, 0, 0, 0, 0, 0);

        step(0, 0);
        push("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Load the first add; stage still empty this cycle
        step(0, 0);
        rst_n = 1'b1;
        drive_id(1, 1, 2, 3, 32'd11, 32'd3, 0, 0, 4'd1, 0, 0, 1, 0, 0);
        push("idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        step(0, 0);
        drive_id(1, 5, 6, 8, 32'h55, 32'h66, 0, 0, 4'd2, 0, 0, 1, 0, 0);
        push("load", 1, 32'd11, 32'd3, 32'd3, 4'd1, 1, 0, 0, 0, 1);

        // Both sources match rs1=5; stall keeps this instruction for the next check
        step(1, 0);
        drive_id(1, 0, 0, 9, 32'h77, 32'h88, 0, 0, 4'd3, 0, 0, 1, 0, 0);
        fwd(1, 5, 32'h10000, 1, 5, 32'd9);
        push("fwd_exmem_wins", 1, 32'h10000, 32'h66, 32'h66, 4'd2, 1, 0, 0, 0, 1);

        step(0, 0);
        fwd(0, 5, 32'h10000, 1, 5, 32'd9);
        push("fwd_memwb", 1, 32'd9, 32'h66, 32'h66, 4'd2, 1, 0, 0, 0, 1);

        // rs1=rs2=x0 with both sources writing x0; then queue a lw x7
        step(0, 0);
        fwd(1, 0, 32'hdead, 1, 0, 32'hbeef);
        drive_id(1, 1, 0, 7, 32'h200, 32'h0, 32'd4, 0, 4'd0, 1, 0, 1, 1, 0);
        push("x0_no_fwd", 1, 32'h77, 32'h88, 32'h88, 4'd3, 1, 0, 0, 0, 1);

        // lw x7 in EX, add x10,x7,x2 in ID
        step(0, 0);
        fwd(0, 0, 0, 0, 0, 0);
        drive_id(1, 7, 2, 10, 32'h1, 32'h20, 0, 0, 4'd0, 0, 0, 1, 0, 0);
        push("load_use_hit", 1, 32'h200, 32'd4, 32'h0, 4'd0, 1, 1, 0, 1, 1);

        step(0, 0);
        fwd(1, 7, 32'haaa, 0, 0, 0);
        push("bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load result now arrives via MEM/WB; next ID slot is a store using imm and pc
        step(0, 0);
        fwd(0, 0, 0, 1, 7, 32'haaa);
        drive_id(1, 3, 4, 5, 32'h30, 32'h40, 32'hFFFF_FFF0, 32'h100, 4'd0, 1, 1, 0, 0, 1);
        push("load_use_fwd", 1, 32'haaa, 32'h20, 32'h20, 4'd0, 1, 0, 0, 0, 1);

        step(1, 1);
        fwd(1, 4, 32'h1234, 0, 0, 0);
        drive_id(1, 1, 2, 12, 32'ha1, 32'hb2, 0, 0, 4'd4, 0, 0, 1, 0, 0);
        push("imm_pc_sel", 1, 32'h100, 32'hFFFF_FFF0, 32'h1234, 4'd0, 0, 0, 1, 0, 1);

        step(0, 0);
        fwd(0, 0, 0, 0, 0, 0);
        push("stall_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Capture, then stall three cycles while ID presents a different instruction
        step(1, 0);
        drive_id(1, 9, 9, 9, 32'hffff, 32'heeee, 32'h5, 32'h8, 4'd7, 1, 1, 0, 0, 1);
        push("capture_k", 1, 32'ha1, 32'hb2, 32'hb2, 4'd4, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            push($sformatf("stall_hold_%0d", i + 1), 1, 32'ha1, 32'hb2, 32'hb2, 4'd4, 1, 0, 0, 0, 1);
        end

        // Reset asserted between edges while stalled
        step(1, 0);
        #2;
        rst_n = 1'b0;
        push("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        step(0, 0);
        rst_n = 1'b1;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
